// File: rtl/hazard3_fetch_lsu_arbiter_pkg.sv
// Shared encodings for the fetch/LSU single-port AHB-Lite arbiter: data-phase
// owner, HTRANS values and HPROT bit positions.
package hazard3_fetch_lsu_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int HPROT_DATA = 0;
  localparam int HPROT_PRIV = 1;

  // Fetch only issues halfword or word transfers.
  function automatic logic [2:0] fetch_hsize(input logic size);
    return size ? 3'd2 : 3'd1;
  endfunction

endpackage

// File: rtl/hazard3_fetch_lsu_arbiter_starve_ctr.sv
// Counts LSU grants taken while fetch is waiting; raises force_i once the
// limit is reached so fetch gets the next address phase.
module hazard3_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  input  logic i_accept,
  input  logic d_accept,
  output logic force_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!i_vld || i_accept) begin
      starve_cnt <= '0;
    end else if (d_accept && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign force_i = (starve_cnt == LIMIT);

endmodule

// File: rtl/hazard3_fetch_lsu_arbiter.sv
// Shares one AHB-Lite manager port between instruction fetch and the LSU,
// with grant locking across wait states and data-phase response routing.
module hazard3_fetch_lsu_arbiter
  import hazard3_fetch_lsu_arbiter_pkg::*;
#(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [W_ADDR-1:0] i_addr,
  input  logic              i_size,
  input  logic              i_priv,
  input  logic              i_vld,
  output logic              i_rdy,
  output logic [W_DATA-1:0] i_rdata,
  output logic              i_err,
  output logic              i_rvld,

  input  logic [W_ADDR-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_write,
  input  logic              d_priv,
  input  logic [W_DATA-1:0] d_wdata,
  input  logic              d_vld,
  output logic              d_rdy,
  output logic [W_DATA-1:0] d_rdata,
  output logic              d_err,
  output logic              d_rvld,

  output logic [W_ADDR-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [3:0]        hprot,
  output logic [W_DATA-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [W_DATA-1:0] hrdata
);

  owner_t grant_sel;
  owner_t lock_sel;
  owner_t dph_owner;
  logic   aph_lock;
  logic   force_i;
  logic   err_first;
  logic   grant_i;
  logic   grant_d;

  hazard3_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_vld    (i_vld),
    .i_accept (i_rdy),
    .d_accept (d_rdy),
    .force_i  (force_i)
  );

  always_comb begin
    grant_sel = OWNER_NONE;
    if (aph_lock)              grant_sel = lock_sel;
    else if (i_vld && force_i) grant_sel = OWNER_I;
    else if (d_vld)            grant_sel = OWNER_D;
    else if (i_vld)            grant_sel = OWNER_I;
  end

  // First cycle of a two-cycle error response cancels any pending address phase.
  assign err_first = hresp & ~hready;
  assign grant_i   = (grant_sel == OWNER_I) & ~err_first;
  assign grant_d   = (grant_sel == OWNER_D) & ~err_first;
  assign i_rdy     = hready & grant_i;
  assign d_rdy     = hready & grant_d;

  always_comb begin
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hprot  = 4'd0;
    if (grant_i) begin
      htrans            = HTRANS_NONSEQ;
      haddr             = i_addr;
      hsize             = fetch_hsize(i_size);
      hprot[HPROT_PRIV] = i_priv;
    end else if (grant_d) begin
      htrans            = HTRANS_NONSEQ;
      haddr             = d_addr;
      hwrite            = d_write;
      hsize             = {1'b0, d_size};
      hprot[HPROT_PRIV] = d_priv;
      hprot[HPROT_DATA] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aph_lock <= 1'b0;
      lock_sel <= OWNER_NONE;
    end else if (err_first || hready) begin
      aph_lock <= 1'b0;
    end else if (grant_i || grant_d) begin
      aph_lock <= 1'b1;
      lock_sel <= grant_sel;
    end
  end

  // ---- address phase -> data phase boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_owner <= OWNER_NONE;
    end else if (hready) begin
      dph_owner <= i_rdy ? OWNER_I : (d_rdy ? OWNER_D : OWNER_NONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwdata <= '0;
    end else if (d_rdy && d_write) begin
      hwdata <= d_wdata;
    end
  end

  assign i_rvld  = hready & (dph_owner == OWNER_I);
  assign d_rvld  = hready & (dph_owner == OWNER_D);
  assign i_rdata = (dph_owner == OWNER_I) ? hrdata : '0;
  assign d_rdata = (dph_owner == OWNER_D) ? hrdata : '0;
  assign i_err   = i_rvld & hresp;
  assign d_err   = d_rvld & hresp;

endmodule

// File: tb/tb_hazard3_fetch_lsu_arbiter.sv
// Randomized bench: a driver predicts address-phase grants from the arbitration
// rules and queues expected responses; a monitor checks them on completion.
module tb_hazard3_fetch_lsu_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_size = 1'b0, i_priv = 1'b0, i_vld = 1'b0;
  logic        i_rdy, i_err, i_rvld;
  logic [31:0] i_rdata;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_write = 1'b0, d_priv = 1'b0, d_vld = 1'b0;
  logic        d_rdy, d_err, d_rvld;
  logic [31:0] d_rdata;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hready = 1'b1, hresp = 1'b0;
  logic [31:0] hrdata = '0;

  hazard3_fetch_lsu_arbiter #(.W_ADDR(32), .W_DATA(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_size(i_size), .i_priv(i_priv), .i_vld(i_vld), .i_rdy(i_rdy),
    .i_rdata(i_rdata), .i_err(i_err), .i_rvld(i_rvld),
    .d_addr(d_addr), .d_size(d_size), .d_write(d_write), .d_priv(d_priv), .d_wdata(d_wdata),
    .d_vld(d_vld), .d_rdy(d_rdy), .d_rdata(d_rdata), .d_err(d_err), .d_rvld(d_rvld),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
    .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  // owner codes in the bench: 0 = nobody, 1 = fetch, 2 = LSU
  typedef struct {
    int          owner;
    logic [31:0] rdata;
    bit          err;
    bit          write;
    logic [31:0] wdata;
    int          waits;
  } txn_t;

  txn_t sb[$];
  txn_t pend;
  txn_t mt;
  bit   pend_valid = 0;
  bit   mon_en = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Data-phase monitor: a response is due whenever the bus completes a queued transfer.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (sb.size() > 0 && hready) begin
        mt = sb.pop_front();
        chk("i_rvld", {31'd0, i_rvld}, {31'd0, mt.owner == 1});
        chk("d_rvld", {31'd0, d_rvld}, {31'd0, mt.owner == 2});
        chk("i_rdata", i_rdata, (mt.owner == 1) ? mt.rdata : 32'd0);
        chk("d_rdata", d_rdata, (mt.owner == 2) ? mt.rdata : 32'd0);
        chk("i_err", {31'd0, i_err}, {31'd0, mt.owner == 1 && mt.err});
        chk("d_err", {31'd0, d_err}, {31'd0, mt.owner == 2 && mt.err});
        if (mt.write) chk("hwdata", hwdata, mt.wdata);
      end else begin
        chk("rvld_idle", {30'd0, i_rvld, d_rvld}, 32'd0);
      end
    end
  end

  int  held = 0, streak = 0, exp_own = 0, acc = 0;
  bit  calm, err_first;
  logic [31:0] e_addr;
  logic [3:0]  e_prot;
  logic [2:0]  e_size;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rdy", {30'd0, i_rdy, d_rdy}, 32'd0);
    chk("rst_rvld_err", {28'd0, i_rvld, d_rvld, i_err, d_err}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if (pend_valid) begin
        sb.push_back(pend);
        pend_valid = 0;
      end
      #1;
      // bus responder
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = $urandom;
      if (sb.size() > 0) begin
        hresp = sb[0].err;
        if (sb[0].waits > 0) begin
          hready = 1'b0;
          sb[0].waits--;
        end else begin
          hrdata = sb[0].rdata;
        end
      end
      // requesters: hold until accepted, then possibly issue a new request
      calm = (cyc < 60);
      if (acc == 1) i_vld = 1'b0;
      if (acc == 2) d_vld = 1'b0;
      if (!i_vld && $urandom_range(99) < (calm ? 100 : 45)) begin
        i_vld  = 1'b1;
        i_addr = $urandom & 32'hffff_fffe;
        i_size = 1'($urandom);
        i_priv = 1'($urandom);
      end
      if (!d_vld && $urandom_range(99) < (calm ? 100 : 45)) begin
        d_vld   = 1'b1;
        d_addr  = $urandom;
        d_size  = 2'($urandom_range(2));
        d_write = 1'($urandom);
        d_priv  = 1'($urandom);
        d_wdata = $urandom;
      end

      @(negedge clk);
      // ---- expected address phase ----
      err_first = hresp && !hready;
      if (held != 0)                       exp_own = held;
      else if (i_vld && streak >= LIMIT)   exp_own = 1;
      else if (d_vld)                      exp_own = 2;
      else if (i_vld)                      exp_own = 1;
      else                                 exp_own = 0;
      if (err_first) exp_own = 0;

      e_addr = (exp_own == 1) ? i_addr : (exp_own == 2) ? d_addr : 32'd0;
      e_size = (exp_own == 1) ? (i_size ? 3'd2 : 3'd1) : (exp_own == 2) ? {1'b0, d_size} : 3'd0;
      e_prot = (exp_own == 1) ? {2'b00, i_priv, 1'b0} : (exp_own == 2) ? {2'b00, d_priv, 1'b1} : 4'd0;
      chk("htrans", {30'd0, htrans}, (exp_own != 0) ? 32'd2 : 32'd0);
      chk("haddr", haddr, e_addr);
      chk("hsize", {29'd0, hsize}, {29'd0, e_size});
      chk("hprot", {28'd0, hprot}, {28'd0, e_prot});
      chk("hwrite", {31'd0, hwrite}, {31'd0, exp_own == 2 && d_write});
      chk("i_rdy", {31'd0, i_rdy}, {31'd0, hready && exp_own == 1});
      chk("d_rdy", {31'd0, d_rdy}, {31'd0, hready && exp_own == 2});

      acc  = hready ? exp_own : 0;
      held = (exp_own != 0 && !hready) ? exp_own : 0;
      if (!i_vld || acc == 1) streak = 0;
      else if (acc == 2 && streak < LIMIT) streak++;

      if (acc != 0) begin
        pend.owner = acc;
        pend.rdata = $urandom;
        pend.err   = !calm && ($urandom_range(9) == 0);
        pend.write = (acc == 2) && d_write;
        pend.wdata = d_wdata;
        pend.waits = pend.err ? 1 : (calm ? 0 : int'($urandom_range(2)));
        pend_valid = 1;
      end
    end

    // asynchronous reset in the middle of traffic drops all ownership
    @(posedge clk);
    #1;
    mon_en = 0;
    i_vld  = 1'b0;
    d_vld  = 1'b0;
    hready = 1'b1;
    hresp  = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("arst_rvld", {30'd0, i_rvld, d_rvld}, 32'd0);
    chk("arst_hwdata", hwdata, 32'd0);
    chk("arst_htrans", {30'd0, htrans}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
